uart_rx_buffered: RTL and testbench
===================================

# uart_rx_buffered

Buffered UART receiver: oversamples the serial line with the system clock, deframes 8N1 characters (LSB first), flags framing and overrun errors, and queues good bytes in a small FIFO drained through a valid/ready handshake. It is the receiving end of the link driven by `UART_TX`. It replaces the bare single-byte pulse interface for consumers that cannot accept a byte in the cycle it arrives.

## Interface
- `CLKS_PER_BIT`, 217: Clock cycles per bit (25 MHz / 115200). Legal range ≥ 8.
- `FIFO_DEPTH`, 4: byte slots. Power of two, ≥ 2.
- `Clock` in 1: single clock; all logic is rising-edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Input_Serial` in 1: asynchronous serial line; idles high.
- `Data_Out` out 8: head-of-FIFO byte. Reset 0.
- `Data_Valid` out 1: FIFO non-empty. Reset 0.
- `Data_Ready` in 1: consumer accepts `Data_Out` when `Data_Valid && Data_Ready` at a Clock edge.
- `Frame_Error` out 1: one-cycle pulse, stop bit sampled low. Reset 0.
- `Overrun_Error` out 1: one-cycle pulse, good byte dropped because the FIFO was full. Reset 0.
- `RX_Busy` out 1: FSM not in IDLE. Reset 0.
- `Fifo_Count` out $clog2(FIFO_DEPTH)+1: occupancy. Reset 0.

## Operation
- Two-flop synchronizer on `Input_Serial`. Both flops reset to 1.
- HALF = (CLKS_PER_BIT-1)/2, integer division. A bit counter counts 0..CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when the synced line is 0, go to START and clear the counter.
  - START: at count HALF, sample the line.
    - Line 0: go to DATA, bit index 0, clear the counter.
    - Line 1: glitch; return to IDLE with no flag.
  - DATA: at count CLKS_PER_BIT-1, sample the line into shift-register bit[index]. After index 7, go to STOP.
  - STOP: at count CLKS_PER_BIT-1, sample the stop bit.
    - Stop bit 1: push the byte into the FIFO; go to IDLE.
    - Stop bit 0: pulse `Frame_Error`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synced line is 1, then go to IDLE. A break condition therefore yields exactly one `Frame_Error`.
- FIFO behaviour:
  - Push when full and no pop in the same cycle: pulse `Overrun_Error` and drop the new byte. Stored bytes are untouched.
  - Push and pop in the same cycle when full: both take effect, no overrun, count unchanged.
  - Push when empty: the byte appears the following cycle. There is no combinational bypass.
  - Order is strictly first-in, first-out. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame: FSM goes to IDLE, FIFO is emptied, the partial byte is lost, and all outputs return to their reset values. After release, a start bit is detected only after the synced line has been seen high.

## Timing
- Let cycle 0 be the first Clock edge at which `Input_Serial` is low.
  - Synced low is visible at cycle 2.
  - Stop-bit sample at E = 2 + HALF + 9·CLKS_PER_BIT. With the defaults, E = 2063.
  - FIFO write at edge E+1. `Data_Valid`/`Data_Out` are valid from E+1 onward, provided the FIFO was empty.
- `Frame_Error` and `Overrun_Error` are high for exactly the one cycle following edge E.
- `Data_Valid` and `Data_Out` hold stable while `Data_Ready` is low.
- The next start bit may be detected from cycle E+1. Back-to-back frames with a single stop bit are supported.
- Tolerated baud mismatch is ±(HALF/(9.5·CLKS_PER_BIT)), about ±5% at the default.

## Structure
- Package `uart_pkg`:
  - FSM state enum (`rx_state_t`)
  - `DEFAULT_CLKS_PER_BIT = 217`
  - a `half_bit(clks)` constant function
- Sub-module `uart_sync_fifo`: parameterized width/depth, push/pop/full/empty/count. It is owned by this block and reusable for a future buffered transmitter.
- The top level holds the synchronizer, bit counter, FSM, shift register and error pulses.

## Test plan
- **Single good byte:** send 0xA5 at 217 clk/bit with `Data_Ready` high. Required: `Data_Valid` rises at cycle 2064 with `Data_Out` = 0xA5, popped the next cycle, no error pulses.
- **Start glitch:** hold the line low for 50 cycles, then high. Required: `RX_Busy` returns low, no byte, no flags. A following 0x3C is received correctly.
- **Framing error:** send 0x3C with the stop bit forced 0, hold low for 3 bit times, then idle. Required: one `Frame_Error` pulse, `Fifo_Count` stays 0. A subsequent 0x55 is received correctly.
- **Overrun:** with `Data_Ready` low, send 0x01..0x05 back-to-back. Required: `Overrun_Error` pulses once, on the fifth byte. Then raising `Data_Ready` drains 0x01, 0x02, 0x03, 0x04 in order.
- **Push/pop when full:** FIFO full (0x01..0x04), and `Data_Ready` high exactly at the write edge of 0x05. Required: no overrun, count stays 4. Drain order is 0x02..0x05.
- **Reset mid-frame:** assert `Reset_n` low during data bit 4 of 0x96. Required: all outputs at reset values within the assert cycle, `Fifo_Count` 0. After release, 0xFF is received correctly.

Source files
------------

// File: rtl/uart_rx_buffered_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the buffered UART receiver and its FIFO.
//   rx_state_t           : receive FSM state encoding
//   DEFAULT_CLKS_PER_BIT : 25 MHz / 115200 baud
//   DEFAULT_FIFO_DEPTH   : byte slots in the receive queue
//   BYTE_W               : character width (8N1 framing)
//   half_bit()           : sample offset from the falling start edge to mid-bit
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 217;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int BYTE_W               = 8;

    function automatic int half_bit(input int clks);
        return (clks - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// ---------------------------------------------------------------------------
// uart_rx_buffered_if
// Byte stream handshake between the receiver (master) and its consumer (slave).
//   Data_Out   : head-of-queue byte
//   Data_Valid : queue non-empty
//   Data_Ready : consumer takes Data_Out when Data_Valid && Data_Ready at an edge
// ---------------------------------------------------------------------------
interface uart_rx_buffered_if;
    import uart_pkg::*;

    logic [BYTE_W-1:0] Data_Out;
    logic              Data_Valid;
    logic              Data_Ready;

    modport master (
        output Data_Out,
        output Data_Valid,
        input  Data_Ready
    );

    modport slave (
        input  Data_Out,
        input  Data_Valid,
        output Data_Ready
    );

endinterface

// File: rtl/uart_rx_buffered_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with registered occupancy. A push while full is dropped
// unless a pop happens in the same cycle, in which case both take effect.
// pop_data reads the head slot directly and is forced to zero while empty, so
// the storage array itself needs no reset.
//   clk, rst_n           : clock, asynchronous active-low reset
//   push, push_data      : write request and data
//   pop, pop_data        : read request and head-of-queue data
//   full, empty, count   : occupancy status
// ---------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// ---------------------------------------------------------------------------
// uart_rx_buffered
// 8N1 UART receiver with a byte queue on the output side.
//   Clock, Reset_n  : system clock, asynchronous active-low reset
//   Input_Serial    : asynchronous serial line, idles high
//   rx_if (master)  : Data_Out / Data_Valid / Data_Ready byte stream
//   Frame_Error     : one-cycle pulse, stop bit sampled low
//   Overrun_Error   : one-cycle pulse, good byte dropped on a full queue
//   RX_Busy         : receiver not idle
//   Fifo_Count      : queue occupancy
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | line idle, waiting for a low level
// ST_START     | timing to mid start bit, rejects glitches
// ST_DATA      | sampling 8 data bits LSB first, one per bit period
// ST_STOP      | sampling the stop bit; push byte or flag framing error
// ST_WAIT_IDLE | after a framing error, hold until the line returns high
// ---------------------------------------------------------------------------
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Input_Serial,
    uart_rx_buffered_if.master  rx_if,
    output logic                Frame_Error,
    output logic                Overrun_Error,
    output logic                RX_Busy,
    output logic [CNT_W-1:0]    Fifo_Count
);

    localparam int BIT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0] HALF_COUNT = BIT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [BIT_W-1:0] LAST_COUNT = BIT_W'(CLKS_PER_BIT - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    rx_state_t         state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;

    logic              rx_line;
    logic              rx_push;
    logic              frame_err;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign rx_line = sync2_q;

    always_comb begin
        sync1_d = Input_Serial;
        sync2_d = sync1_q;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_push   = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!rx_line) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (bit_cnt_q == HALF_COUNT) begin
                    bit_cnt_d = '0;
                    if (!rx_line) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_cnt_q == LAST_COUNT) begin
                    bit_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_line;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end

            ST_STOP: begin
                // The push and the error pulse are decoded from the final
                // stop-bit count so they are visible in the cycle before the
                // state moves on; the FIFO captures the byte at that edge.
                if (bit_cnt_q == LAST_COUNT) begin
                    bit_cnt_d = '0;
                    if (rx_line) begin
                        rx_push = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end

            ST_WAIT_IDLE: begin
                bit_cnt_d = '0;
                if (rx_line) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .push      (rx_push),
        .push_data (shift_q),
        .pop       (rx_if.Data_Ready),
        .pop_data  (rx_if.Data_Out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (Fifo_Count)
    );

    // A pop in the same cycle frees the slot, so only a push against a full
    // queue with no consumer transfer loses data.
    assign fifo_pop         = !fifo_empty && rx_if.Data_Ready;
    assign rx_if.Data_Valid = !fifo_empty;
    assign Overrun_Error    = rx_push && fifo_full && !fifo_pop;
    assign Frame_Error      = frame_err;
    assign RX_Busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
module tb_uart_rx_buffered;
    import uart_pkg::*;

    localparam int CPB       = DEFAULT_CLKS_PER_BIT;
    // 2 (sync) + 108 (half bit) + 9*217 = 2063; the FIFO write is one edge later
    localparam int LAT_ERR   = 2063;
    localparam int LAT_VALID = 2064;

    logic       Clock        = 1'b0;
    logic       Reset_n      = 1'b0;
    logic       Input_Serial = 1'b1;
    logic       Frame_Error;
    logic       Overrun_Error;
    logic       RX_Busy;
    logic [2:0] Fifo_Count;

    uart_rx_buffered_if rx_if();

    uart_rx_buffered dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Input_Serial  (Input_Serial),
        .rx_if         (rx_if),
        .Frame_Error   (Frame_Error),
        .Overrun_Error (Overrun_Error),
        .RX_Busy       (RX_Busy),
        .Fifo_Count    (Fifo_Count)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int         checks    = 0;
    int         errors    = 0;
    int         t0        = 0;
    int         frame_cnt = 0;
    int         ovr_cnt   = 0;
    int         frame_cyc = -1;
    int         ovr_cyc   = -1;
    int         rise_cyc  = -1;
    int         fall_cyc  = -1;
    logic [7:0] rise_data = 8'h00;
    logic       dv_prev   = 1'b0;
    logic [7:0] rx_q [$];

    always @(negedge Clock) begin
        if (Frame_Error === 1'b1) begin
            frame_cnt++;
            frame_cyc = cyc;
        end
        if (Overrun_Error === 1'b1) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (rx_if.Data_Valid === 1'b1 && dv_prev !== 1'b1) begin
            rise_cyc  = cyc;
            rise_data = rx_if.Data_Out;
        end
        if (rx_if.Data_Valid !== 1'b1 && dv_prev === 1'b1) fall_cyc = cyc;
        dv_prev = rx_if.Data_Valid;
        if (Reset_n === 1'b1 && rx_if.Data_Valid === 1'b1 && rx_if.Data_Ready === 1'b1)
            rx_q.push_back(rx_if.Data_Out);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        Input_Serial = v;
        tick(n);
    endtask

    // Called at posedge+1; the next edge is cycle 0 of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        t0 = cyc + 1;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
    endtask

    int         fb;
    int         ob;
    logic [7:0] b96 = 8'h96;

    initial begin
        rx_if.Data_Ready = 1'b0;
        tick(3);

        // reset state
        check("rst_data_out",  rx_if.Data_Out,   8'h00);
        check("rst_valid",     rx_if.Data_Valid, 1'b0);
        check("rst_frame",     Frame_Error,      1'b0);
        check("rst_overrun",   Overrun_Error,    1'b0);
        check("rst_busy",      RX_Busy,          1'b0);
        check("rst_count",     Fifo_Count,       3'd0);
        Reset_n = 1'b1;
        tick(10);

        // single good byte
        rx_if.Data_Ready = 1'b1;
        rx_q.delete();
        fb = frame_cnt; ob = ovr_cnt;
        send_frame(8'hA5, 1'b1);
        tick(5);
        check("t1_valid_latency", rise_cyc - t0, LAT_VALID);
        check("t1_data",          rise_data, 8'hA5);
        check("t1_valid_width",   fall_cyc - rise_cyc, 1);
        check("t1_rx_bytes",      rx_q.size(), 1);
        check("t1_frame",         frame_cnt - fb, 0);
        check("t1_overrun",       ovr_cnt - ob, 0);

        // start glitch
        rx_q.delete();
        fb = frame_cnt;
        Input_Serial = 1'b0;
        tick(20);
        check("t2_busy_in_start", RX_Busy, 1'b1);
        tick(30);
        Input_Serial = 1'b1;
        tick(200);
        check("t2_busy_cleared", RX_Busy, 1'b0);
        check("t2_no_byte",      rx_q.size(), 0);
        check("t2_count",        Fifo_Count, 3'd0);
        check("t2_frame",        frame_cnt - fb, 0);
        send_frame(8'h3C, 1'b1);
        tick(5);
        check("t2_rx_bytes", rx_q.size(), 1);
        check("t2_rx_3c",    rx_q[0], 8'h3C);

        // framing error followed by a break
        rx_q.delete();
        fb = frame_cnt;
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 3 * CPB);
        Input_Serial = 1'b1;
        tick(50);
        check("t3_frame_pulses", frame_cnt - fb, 1);
        check("t3_frame_cycle",  frame_cyc - t0, LAT_ERR);
        check("t3_count",        Fifo_Count, 3'd0);
        check("t3_no_byte",      rx_q.size(), 0);
        check("t3_busy",         RX_Busy, 1'b0);
        send_frame(8'h55, 1'b1);
        tick(5);
        check("t3_rx_bytes", rx_q.size(), 1);
        check("t3_rx_55",    rx_q[0], 8'h55);

        // overrun with the consumer stalled
        rx_if.Data_Ready = 1'b0;
        tick(2);
        rx_q.delete();
        ob = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("t4_count_full", Fifo_Count, 3'd4);
        check("t4_no_overrun_yet", ovr_cnt - ob, 0);
        send_frame(8'h05, 1'b1);
        tick(2);
        check("t4_overrun_pulses", ovr_cnt - ob, 1);
        check("t4_overrun_cycle",  ovr_cyc - t0, LAT_ERR);
        check("t4_count_held",     Fifo_Count, 3'd4);
        check("t4_head_held",      rx_if.Data_Out, 8'h01);
        check("t4_valid_held",     rx_if.Data_Valid, 1'b1);
        rx_if.Data_Ready = 1'b1;
        tick(8);
        check("t4_drain_size", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_drain%0d", i), rx_q[i], 8'(i + 1));
        check("t4_count_empty", Fifo_Count, 3'd0);

        // push and pop on the same edge while full
        rx_if.Data_Ready = 1'b0;
        tick(2);
        rx_q.delete();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("t5_count_full", Fifo_Count, 3'd4);
        ob = ovr_cnt;
        fork
            send_frame(8'h05, 1'b1);
            begin
                tick(LAT_ERR + 1);
                rx_if.Data_Ready = 1'b1;
                tick(1);
                rx_if.Data_Ready = 1'b0;
            end
        join
        tick(2);
        check("t5_no_overrun",  ovr_cnt - ob, 0);
        check("t5_count_held",  Fifo_Count, 3'd4);
        check("t5_one_pop",     rx_q.size(), 1);
        check("t5_popped_01",   rx_q[0], 8'h01);
        rx_if.Data_Ready = 1'b1;
        tick(8);
        check("t5_drain_size", rx_q.size(), 5);
        for (int i = 1; i < 5; i++)
            check($sformatf("t5_drain%0d", i), rx_q[i], 8'(i + 1));

        // reset in the middle of a frame with a byte already queued
        rx_if.Data_Ready = 1'b0;
        tick(2);
        rx_q.delete();
        send_frame(8'h11, 1'b1);
        tick(2);
        check("t6_queued", Fifo_Count, 3'd1);
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(b96[i], CPB);
        drive(b96[4], CPB / 2);
        check("t6_busy_mid_frame", RX_Busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("t6_rst_valid",   rx_if.Data_Valid, 1'b0);
        check("t6_rst_data",    rx_if.Data_Out,   8'h00);
        check("t6_rst_count",   Fifo_Count,       3'd0);
        check("t6_rst_busy",    RX_Busy,          1'b0);
        check("t6_rst_frame",   Frame_Error,      1'b0);
        check("t6_rst_overrun", Overrun_Error,    1'b0);
        Input_Serial = 1'b1;
        tick(5);
        Reset_n = 1'b1;
        tick(5);
        rx_if.Data_Ready = 1'b1;
        tick(20);
        check("t6_no_stale", rx_q.size(), 0);
        send_frame(8'hFF, 1'b1);
        tick(5);
        check("t6_rx_bytes", rx_q.size(), 1);
        check("t6_rx_ff",    rx_q[0], 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
